beam_combiner: RTL and testbench

Gathers fixed-length bursts from three ADC AXI-Stream inputs into a single packetized AXI-Stream output with `tlast`. It is the acquisition-side counterpart of the beam DAC distribution path: the selected channel's burst is forwarded beat-for-beat, and the last beat of each burst is framed with `tlast`. An output register slice provides full throughput and a registered output interface.

---
 rtl/beam_pkg.sv | 17 +
 rtl/axis_skid_buffer.sv | 67 ++++++
 rtl/beam_combiner.sv | 155 +++++++++++++++
 tb/tb_beam_combiner.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/beam_pkg.sv
// beam_pkg: shared types and constants for the beam ADC combiner.
package beam_pkg;
  localparam int NUM_CH = 3;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    CH0        = 2'd0,
    CH1        = 2'd1,
    CH2        = 2'd2,
    CH_INVALID = 2'd3
  } adc_sel_t;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } comb_state_t;
endpackage

// File: rtl/axis_skid_buffer.sv
// axis_skid_buffer: 2-entry output register slice. The output entry drives the
// sink directly; the skid entry catches the one beat that can arrive after the
// sink stalls. Input ready is simply "skid entry empty", so it comes from a flop.
module axis_skid_buffer #(
  parameter int W = 33
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_data,
  input  logic         i_valid,
  output logic         o_ready,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  input  logic         i_ready
);
  logic         out_vld_q, out_vld_d;
  logic [W-1:0] out_dat_q, out_dat_d;
  logic         skd_vld_q, skd_vld_d;
  logic [W-1:0] skd_dat_q, skd_dat_d;
  logic         in_fire, out_fire;

  assign in_fire  = i_valid && !skd_vld_q;
  assign out_fire = out_vld_q && i_ready;

  // Next entry contents: skid refills the output first, then new beats.
  always_comb begin
    out_vld_d = out_vld_q;
    out_dat_d = out_dat_q;
    skd_vld_d = skd_vld_q;
    skd_dat_d = skd_dat_q;
    if (skd_vld_q) begin
      if (out_fire) begin
        out_dat_d = skd_dat_q;
        skd_vld_d = 1'b0;
      end
    end else if (in_fire) begin
      if (!out_vld_q || out_fire) begin
        out_vld_d = 1'b1;
        out_dat_d = i_data;
      end else begin
        skd_vld_d = 1'b1;
        skd_dat_d = i_data;
      end
    end else if (out_fire) begin
      out_vld_d = 1'b0;
    end
  end

  // Entry registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      out_vld_q <= 1'b0;
      out_dat_q <= '0;
      skd_vld_q <= 1'b0;
      skd_dat_q <= '0;
    end else begin
      out_vld_q <= out_vld_d;
      out_dat_q <= out_dat_d;
      skd_vld_q <= skd_vld_d;
      skd_dat_q <= skd_dat_d;
    end
  end

  assign o_ready = !skd_vld_q;
  assign o_valid = out_vld_q;
  assign o_data  = out_dat_q;
endmodule

// File: rtl/beam_combiner.sv
// beam_combiner: forwards fixed-length bursts from one of three ADC streams to
// a single framed output stream through a register slice.
// Optional macro BEAM_COMBINER_RR_EN: round-robin channel pick instead of
// i_adc_sel (o_sel_error then stays 0).
module beam_combiner
  import beam_pkg::*;
#(
  parameter int DATA_W    = beam_pkg::DATA_W,
  parameter int BURST_LEN = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] axis_adc0_tdata,
  input  logic              axis_adc0_tvalid,
  output logic              axis_adc0_tready,
  input  logic [DATA_W-1:0] axis_adc1_tdata,
  input  logic              axis_adc1_tvalid,
  output logic              axis_adc1_tready,
  input  logic [DATA_W-1:0] axis_adc2_tdata,
  input  logic              axis_adc2_tvalid,
  output logic              axis_adc2_tready,
  input  logic [1:0]        i_adc_sel,
  output logic [DATA_W-1:0] axis_sink_tdata,
  output logic              axis_sink_tvalid,
  input  logic              axis_sink_tready,
  output logic              axis_sink_tlast,
  output logic              o_burst_active,
  output logic              o_sel_error
);
  localparam int                CNT_W    = $clog2(BURST_LEN);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(BURST_LEN - 1);

  logic [NUM_CH-1:0][DATA_W-1:0] adc_data;
  logic [NUM_CH-1:0]             adc_valid, adc_ready;

  comb_state_t      state_q, state_d;
  adc_sel_t         sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sel_err_q, sel_err_d;

  logic              skid_in_valid, skid_ready, in_fire;
  logic [DATA_W:0]   skid_in_data, skid_out_data;

`ifdef BEAM_COMBINER_RR_EN
  adc_sel_t   last_q, last_d;
  logic       rr_found;
  adc_sel_t   rr_pick;
  logic [1:0] rr_idx;
`endif

  assign adc_data  = {axis_adc2_tdata, axis_adc1_tdata, axis_adc0_tdata};
  assign adc_valid = {axis_adc2_tvalid, axis_adc1_tvalid, axis_adc0_tvalid};
  assign {axis_adc2_tready, axis_adc1_tready, axis_adc0_tready} = adc_ready;
  assign in_fire = skid_in_valid && skid_ready;

  // FSM state, latched channel, beat counter, error pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      sel_q     <= CH0;
      cnt_q     <= '0;
      sel_err_q <= 1'b0;
`ifdef BEAM_COMBINER_RR_EN
      last_q    <= CH2;
`endif
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      sel_err_q <= sel_err_d;
`ifdef BEAM_COMBINER_RR_EN
      last_q    <= last_d;
`endif
    end
  end

  // Next state: pick a channel in IDLE, count beats in BURST.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    sel_err_d = 1'b0;
`ifdef BEAM_COMBINER_RR_EN
    last_d   = last_q;
    rr_found = 1'b0;
    rr_pick  = CH0;
    rr_idx   = 2'd0;
`endif
    case (state_q)
      IDLE: begin
`ifdef BEAM_COMBINER_RR_EN
        // Search upward from last-served+1, wrapping at NUM_CH.
        for (int k = 1; k <= NUM_CH; k++) begin
          rr_idx = 2'((int'(last_q) + k) % NUM_CH);
          if (!rr_found && adc_valid[rr_idx]) begin
            rr_found = 1'b1;
            rr_pick  = adc_sel_t'(rr_idx);
          end
        end
        if (rr_found) begin
          state_d = BURST;
          sel_d   = rr_pick;
          last_d  = rr_pick;
          cnt_d   = '0;
        end
`else
        if (i_adc_sel != 2'(CH_INVALID)) begin
          if (adc_valid[i_adc_sel]) begin
            state_d = BURST;
            sel_d   = adc_sel_t'(i_adc_sel);
            cnt_d   = '0;
          end
        end else if (|adc_valid) begin
          sel_err_d = 1'b1;
        end
`endif
      end
      BURST: begin
        if (in_fire) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: only the latched channel is ever ready, and only in BURST.
  always_comb begin
    adc_ready      = '0;
    skid_in_valid  = 1'b0;
    o_burst_active = (state_q == BURST);
    skid_in_data   = {adc_data[sel_q], (cnt_q == LAST_CNT)};
    if (state_q == BURST) begin
      adc_ready[sel_q] = skid_ready;
      skid_in_valid    = adc_valid[sel_q];
    end
  end

  assign o_sel_error = sel_err_q;

  axis_skid_buffer #(.W(DATA_W + 1)) u_slice (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_data  (skid_in_data),
    .i_valid (skid_in_valid),
    .o_ready (skid_ready),
    .o_data  (skid_out_data),
    .o_valid (axis_sink_tvalid),
    .i_ready (axis_sink_tready)
  );

  assign axis_sink_tdata = skid_out_data[DATA_W:1];
  assign axis_sink_tlast = skid_out_data[0];
endmodule

// File: tb/tb_beam_combiner.sv
// tb_beam_combiner: directed bench for beam_combiner with BURST_LEN=4.
module tb_beam_combiner;
  localparam int DW = 32;
  localparam int BL = 4;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic [2:0]    vld;
  logic [DW-1:0] dat [3];
  logic [2:0]    rdy;
  logic [1:0]    sel;
  logic [DW-1:0] sink_tdata;
  logic          sink_tvalid, sink_tready, sink_tlast;
  logic          burst_active, sel_error;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] q0[$], q1[$], q2[$];
  logic [DW-1:0] rx_d[$], exp_d[$];
  logic          rx_l[$];
  int            rx_c[$];
  int            cyc = 0;
  int            pops[3];
  logic [2:0]    allow, bad_rdy;
  logic          toggle, stall_p;
  logic [DW-1:0] hold_d;
  logic          hold_l;

  always #5 i_clk = ~i_clk;

  beam_combiner #(.DATA_W(DW), .BURST_LEN(BL)) dut (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .axis_adc0_tdata  (dat[0]),
    .axis_adc0_tvalid (vld[0]),
    .axis_adc0_tready (rdy[0]),
    .axis_adc1_tdata  (dat[1]),
    .axis_adc1_tvalid (vld[1]),
    .axis_adc1_tready (rdy[1]),
    .axis_adc2_tdata  (dat[2]),
    .axis_adc2_tvalid (vld[2]),
    .axis_adc2_tready (rdy[2]),
    .i_adc_sel        (sel),
    .axis_sink_tdata  (sink_tdata),
    .axis_sink_tvalid (sink_tvalid),
    .axis_sink_tready (sink_tready),
    .axis_sink_tlast  (sink_tlast),
    .o_burst_active   (burst_active),
    .o_sel_error      (sel_error)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic refresh();
    vld[0] = (q0.size() != 0); dat[0] = vld[0] ? q0[0] : '0;
    vld[1] = (q1.size() != 0); dat[1] = vld[1] ? q1[0] : '0;
    vld[2] = (q2.size() != 0); dat[2] = vld[2] ? q2[0] : '0;
  endtask

  // One clock: observe at negedge, advance, then update sources at next negedge.
  task automatic tick();
    logic [2:0] hs;
    hs = vld & rdy;
    if (stall_p && sink_tvalid) begin
      chk("stable_data", 64'(sink_tdata), 64'(hold_d));
      chk("stable_last", 64'(sink_tlast), 64'(hold_l));
    end
    stall_p = sink_tvalid && !sink_tready;
    hold_d  = sink_tdata;
    hold_l  = sink_tlast;
    if (sink_tvalid && sink_tready) begin
      rx_d.push_back(sink_tdata);
      rx_l.push_back(sink_tlast);
      rx_c.push_back(cyc);
    end
    bad_rdy = bad_rdy | (rdy & ~allow);
    @(posedge i_clk);
    cyc++;
    @(negedge i_clk);
    if (hs[0]) begin void'(q0.pop_front()); pops[0]++; end
    if (hs[1]) begin void'(q1.pop_front()); pops[1]++; end
    if (hs[2]) begin void'(q2.pop_front()); pops[2]++; end
    refresh();
    if (toggle) sink_tready = ~sink_tready;
  endtask

  task automatic start_test(input logic [2:0] mask);
    rx_d.delete(); rx_l.delete(); rx_c.delete(); exp_d.delete();
    pops[0] = 0; pops[1] = 0; pops[2] = 0;
    allow = mask; bad_rdy = '0;
  endtask

  task automatic run_until(input int n);
    for (int b = 0; b < 60 && rx_d.size() < n; b++) tick();
  endtask

  // Compare received beats against exp_d; tlast expected on every BL-th beat.
  task automatic cmp_rx(input string tag);
    chk({tag, "_count"}, 64'(rx_d.size()), 64'(exp_d.size()));
    for (int i = 0; i < exp_d.size() && i < rx_d.size(); i++) begin
      chk({tag, "_data"}, 64'(rx_d[i]), 64'(exp_d[i]));
      chk({tag, "_last"}, 64'(rx_l[i]), 64'((i % BL) == BL - 1));
    end
  endtask

  initial begin
    i_rst_n = 1'b0; sel = 2'd0; sink_tready = 1'b1; toggle = 1'b0; stall_p = 1'b0;
    allow = '0; bad_rdy = '0;
    refresh();
    repeat (2) @(negedge i_clk);
    // Reset state
    chk("rst_rdy", 64'(rdy), 64'(0));
    chk("rst_sink_vld", 64'(sink_tvalid), 64'(0));
    chk("rst_sink_last", 64'(sink_tlast), 64'(0));
    chk("rst_sink_data", 64'(sink_tdata), 64'(0));
    chk("rst_active", 64'(burst_active), 64'(0));
    chk("rst_err", 64'(sel_error), 64'(0));
    i_rst_n = 1'b1;
    @(negedge i_clk);

`ifdef BEAM_COMBINER_RR_EN
    // Round robin with all channels valid: order 0,1,2,0.
    start_test(3'b111);
    q0 = '{32'h01, 32'h02, 32'h03, 32'h04, 32'h05, 32'h06, 32'h07, 32'h08};
    q1 = '{32'h11, 32'h12, 32'h13, 32'h14};
    q2 = '{32'h21, 32'h22, 32'h23, 32'h24};
    sel = 2'd3;
    refresh();
    exp_d = '{32'h01, 32'h02, 32'h03, 32'h04, 32'h11, 32'h12, 32'h13, 32'h14,
              32'h21, 32'h22, 32'h23, 32'h24, 32'h05, 32'h06, 32'h07, 32'h08};
    run_until(16);
    cmp_rx("rr");
    chk("rr_err", 64'(sel_error), 64'(0));
`else
    // Basic burst from channel 1, sink always ready.
    start_test(3'b010);
    sel = 2'd1;
    q1 = '{32'h11, 32'h12, 32'h13, 32'h14};
    refresh();
    tick();
    chk("t1_active", 64'(burst_active), 64'(1));
    chk("t1_rdy", 64'(rdy), 64'(3'b010));
    exp_d = '{32'h11, 32'h12, 32'h13, 32'h14};
    run_until(4);
    cmp_rx("t1");
    if (rx_c.size() == 4) chk("t1_back2back", 64'(rx_c[3] - rx_c[0]), 64'(3));
    chk("t1_idle_after", 64'(burst_active), 64'(0));
    chk("t1_drained", 64'(sink_tvalid), 64'(0));
    chk("t1_other_rdy", 64'(bad_rdy), 64'(0));
    repeat (2) tick();

    // Backpressure: sink ready toggles every cycle, channel 0.
    start_test(3'b001);
    sel = 2'd0; toggle = 1'b1;
    q0 = '{32'hA1, 32'hA2, 32'hA3, 32'hA4};
    refresh();
    exp_d = '{32'hA1, 32'hA2, 32'hA3, 32'hA4};
    run_until(4);
    cmp_rx("t2");
    toggle = 1'b0; sink_tready = 1'b1;
    repeat (3) tick();
    chk("t2_no_extra", 64'(rx_d.size()), 64'(4));
    chk("t2_other_rdy", 64'(bad_rdy), 64'(0));

    // Illegal select with channel 2 valid.
    start_test(3'b000);
    sel = 2'd3;
    q2 = '{32'h77};
    refresh();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_err", 64'(sel_error), 64'(1));
      chk("t3_rdy", 64'(rdy), 64'(0));
      chk("t3_sink", 64'(sink_tvalid), 64'(0));
    end
    q2.delete(); refresh();
    tick();
    chk("t3_err_clear", 64'(sel_error), 64'(0));
    chk("t3_active", 64'(burst_active), 64'(0));

    // Select change mid-burst: channel 0 finishes, then channel 2.
    start_test(3'b101);
    sel = 2'd0;
    q0 = '{32'hB1, 32'hB2, 32'hB3, 32'hB4};
    q2 = '{32'hC1, 32'hC2, 32'hC3, 32'hC4};
    refresh();
    for (int b = 0; b < 60 && rx_d.size() < 8; b++) begin
      tick();
      if (pops[0] == 2) sel = 2'd2;
    end
    exp_d = '{32'hB1, 32'hB2, 32'hB3, 32'hB4, 32'hC1, 32'hC2, 32'hC3, 32'hC4};
    cmp_rx("t4");
    if (rx_c.size() == 8) chk("t4_gap", 64'(rx_c[4] - rx_c[3]), 64'(2));
    chk("t4_other_rdy", 64'(bad_rdy), 64'(0));
    repeat (2) tick();

    // Reset after 3 of 4 beats, then a clean burst.
    start_test(3'b010);
    sel = 2'd1;
    q1 = '{32'hD1, 32'hD2, 32'hD3, 32'hD4};
    refresh();
    for (int b = 0; b < 20 && pops[1] < 3; b++) tick();
    chk("t5_pre_vld", 64'(sink_tvalid), 64'(1));
    #2 i_rst_n = 1'b0;
    #1;
    chk("t5_rst_vld", 64'(sink_tvalid), 64'(0));
    chk("t5_rst_last", 64'(sink_tlast), 64'(0));
    chk("t5_rst_data", 64'(sink_tdata), 64'(0));
    chk("t5_rst_rdy", 64'(rdy), 64'(0));
    chk("t5_rst_active", 64'(burst_active), 64'(0));
    q1.delete(); refresh(); stall_p = 1'b0;
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    start_test(3'b010);
    q1 = '{32'hE1, 32'hE2, 32'hE3, 32'hE4};
    refresh();
    exp_d = '{32'hE1, 32'hE2, 32'hE3, 32'hE4};
    run_until(4);
    cmp_rx("t5");
    chk("t5_other_rdy", 64'(bad_rdy), 64'(0));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
